dmem_port_arbiter: RTL

Shares the single data-memory port between the pipeline's MEM stage and a burst DMA engine, such as a boot loader or peripheral copy engine. The CPU has priority. A fairness counter guarantees the DMA a slot after a bounded wait, and `cpu_stall` freezes the pipeline when the CPU loses arbitration. The block sits between the EX/MEM register outputs and the data memory.

---
 rtl/dmem_port_arbiter_if.sv | 50 +++++
 rtl/dmem_port_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: bundles the CPU MEM-stage, DMA engine and data-memory
// signals that meet at the data-memory port arbiter.
// slave  = arbiter view, master = requesters/memory view.
interface dmem_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);

  logic              cpu_re;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_start;
  logic              dma_write;
  logic [DATA_W-1:0] dma_base;
  logic [LEN_W-1:0]  dma_len;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_beat;
  logic              dma_busy;
  logic              dma_done;

  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_start, dma_write, dma_base, dma_len, dma_wdata,
    output dma_rdata, dma_beat, dma_busy, dma_done,
    output mem_addr, mem_wdata, mem_re, mem_we,
    input  mem_rdata
  );

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_start, dma_write, dma_base, dma_len, dma_wdata,
    input  dma_rdata, dma_beat, dma_busy, dma_done,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the pipeline
// MEM stage (priority owner) and a burst DMA engine.
// Optional macro DMEM_ARB_FAIR_EN: when defined, a wait counter forces a DMA
// beat after MAX_WAIT denied cycles; when undefined the CPU has strict
// priority and the DMA may starve.
module dmem_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 8,
  parameter int MAX_WAIT = 4
) (
  input logic              clk,
  input logic              reset,
  dmem_port_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic              dir;
  logic [DATA_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remain;
  logic              cpu_req;
  logic              in_run;
  logic              dma_win;

  assign cpu_req = bus.cpu_re | bus.cpu_we;
  assign in_run  = (state == ST_RUN);

`ifdef DMEM_ARB_FAIR_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  // A denied DMA wins once it has waited MAX_WAIT CPU-owned cycles
  always_comb begin
    dma_win = in_run && (!cpu_req || (wait_cnt == WAIT_MAX));
  end

  // Count CPU-won RUN cycles; a beat or leaving RUN clears the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!in_run || dma_win) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign bus.cpu_stall = dma_win & cpu_req;
`else
  // Strict priority: the DMA only uses cycles the CPU leaves free
  always_comb begin
    dma_win = in_run && !cpu_req;
  end

  assign bus.cpu_stall = 1'b0;
`endif

  // Steer the memory port to the DMA on a beat, otherwise pass the CPU through
  always_comb begin
    if (dma_win) begin
      bus.mem_addr  = cur_addr;
      bus.mem_wdata = bus.dma_wdata;
      bus.mem_re    = ~dir;
      bus.mem_we    = dir;
      bus.dma_rdata = bus.mem_rdata;
    end else begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_re    = bus.cpu_re;
      bus.mem_we    = bus.cpu_we;
      bus.dma_rdata = '0;
    end
  end

  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dma_beat  = dma_win;
  assign bus.dma_busy  = in_run;
  assign bus.dma_done  = (state == ST_DONE);

  // Burst sequencing: latch parameters on start, advance one word per beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      dir      <= 1'b0;
      cur_addr <= '0;
      remain   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.dma_start) begin
            dir      <= bus.dma_write;
            cur_addr <= {bus.dma_base[DATA_W-1:2], 2'b00};
            remain   <= bus.dma_len;
            state    <= (bus.dma_len != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (dma_win) begin
            cur_addr <= cur_addr + DATA_W'(4);
            remain   <= remain - LEN_W'(1);
            if (remain == LEN_W'(1)) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
